// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and helpers for the one-hot register-select decoder.
//   state_e : sequencer states (IDLE, SCAN)
//   onehot  : one-hot vector of idx within n outputs; zero when idx >= n
package ctrl_pkg;

   // Widest decoder the helper can serve; callers cast down to N_OUT.
   localparam int unsigned MAX_OUT = 1024;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   // Shift form keeps the index width free of any relation to MAX_OUT.
   function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx,
                                                 input int unsigned n);
      logic [MAX_OUT-1:0] v;
      v = '0;
      if (idx < n && idx < MAX_OUT) begin
         v = MAX_OUT'(1) << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Control-unit <-> decoder bus.
//   master : drives en/sel, scan_start/first/last, scan_abort; observes results
//   slave  : decoder side; drives dec_out, dec_idx, busy, done, err
interface onehot_decoder_seq_if #(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned N_OUT = 16
);
   logic             en;
   logic [SEL_W-1:0] sel;
   logic             scan_start;
   logic [SEL_W-1:0] scan_first;
   logic [SEL_W-1:0] scan_last;
   logic             scan_abort;
   logic [N_OUT-1:0] dec_out;
   logic [SEL_W-1:0] dec_idx;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output en, sel, scan_start, scan_first, scan_last, scan_abort,
      input  dec_out, dec_idx, busy, done, err
   );

   modport slave (
      input  en, sel, scan_start, scan_first, scan_last, scan_abort,
      output dec_out, dec_idx, busy, done, err
   );
endinterface

// File: rtl/onehot_decoder_seq_enc_reg.sv
// One-hot encoder with output register, shared by DIRECT and SCAN modes.
//   clock, clear_n : clock and synchronous active-low clear
//   load, idx      : when load is high, register onehot(idx); otherwise zero
//   dec_out        : registered one-hot (or all-zero) output
//   dec_idx        : registered index of the set bit; 0 when dec_out is zero
module onehot_enc_reg
   import ctrl_pkg::*;
#(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned N_OUT = 16
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             load,
   input  logic [SEL_W-1:0] idx,
   output logic [N_OUT-1:0] dec_out,
   output logic [SEL_W-1:0] dec_idx
);

   // Out-of-range indices register as all-zero so no X/garbage ever leaves.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         dec_out <= '0;
         dec_idx <= '0;
      end else if (load && (32'(idx) < N_OUT)) begin
         dec_out <= N_OUT'(onehot(32'(idx), N_OUT));
         dec_idx <= idx;
      end else begin
         dec_out <= '0;
         dec_idx <= '0;
      end
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot register-select decoder with a SCAN sequencer.
//   clock, clear_n : clock and synchronous active-low reset
//   bus (slave)    : en/sel direct decode, scan_start/first/last/abort
//                    sequencing; dec_out/dec_idx/busy/done/err results
module onehot_decoder_seq
   import ctrl_pkg::*;
#(
   parameter int unsigned SEL_W = 4,
   parameter int unsigned N_OUT = 16,
   parameter int unsigned DWELL = 1
) (
   input  logic                  clock,
   input  logic                  clear_n,
   onehot_decoder_seq_if.slave   bus
);

   localparam int unsigned DW_W = $clog2(DWELL + 1);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             load_c;
   logic [SEL_W-1:0] enc_idx_c;
   logic             range_ok_c;
   logic             sel_ok_c;

   assign range_ok_c = (bus.scan_first <= bus.scan_last) &&
                       (32'(bus.scan_last) < N_OUT);
   assign sel_ok_c   = (32'(bus.sel) < N_OUT);

   // Next-state, counters and encoder request; err/done default to no pulse.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      dwell_d   = dwell_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      load_c    = 1'b0;
      enc_idx_c = '0;

      case (state_q)
         IDLE: begin
            if (bus.scan_start) begin
               if (range_ok_c) begin
                  state_d   = SCAN;
                  idx_d     = bus.scan_first;
                  last_d    = bus.scan_last;
                  dwell_d   = DW_W'(1);
                  busy_d    = 1'b1;
                  load_c    = 1'b1;
                  enc_idx_c = bus.scan_first;
               end else begin
                  err_d = 1'b1;
               end
            end else if (bus.en) begin
               if (sel_ok_c) begin
                  load_c    = 1'b1;
                  enc_idx_c = bus.sel;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         SCAN: begin
            if (bus.scan_abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (dwell_q == DW_W'(DWELL)) begin
               if (idx_q == last_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d     = idx_q + SEL_W'(1);
                  dwell_d   = DW_W'(1);
                  load_c    = 1'b1;
                  enc_idx_c = idx_q + SEL_W'(1);
               end
            end else begin
               dwell_d   = dwell_q + DW_W'(1);
               load_c    = 1'b1;
               enc_idx_c = idx_q;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state and status registers.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         dwell_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   onehot_enc_reg #(
      .SEL_W (SEL_W),
      .N_OUT (N_OUT)
   ) u_enc (
      .clock   (clock),
      .clear_n (clear_n),
      .load    (load_c),
      .idx     (enc_idx_c),
      .dec_out (bus.dec_out),
      .dec_idx (bus.dec_idx)
   );

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench: three decoder instances (16/DWELL1, 12/DWELL1, 16/DWELL2).
module tb_onehot_decoder_seq;

   logic clock;
   logic clear_n;
   int   checks;
   int   errors;

   onehot_decoder_seq_if #(.SEL_W(4), .N_OUT(16)) if16 ();
   onehot_decoder_seq_if #(.SEL_W(4), .N_OUT(12)) if12 ();
   onehot_decoder_seq_if #(.SEL_W(4), .N_OUT(16)) ifd2 ();

   onehot_decoder_seq #(.SEL_W(4), .N_OUT(16), .DWELL(1)) u16 (
      .clock (clock), .clear_n (clear_n), .bus (if16));
   onehot_decoder_seq #(.SEL_W(4), .N_OUT(12), .DWELL(1)) u12 (
      .clock (clock), .clear_n (clear_n), .bus (if12));
   onehot_decoder_seq #(.SEL_W(4), .N_OUT(16), .DWELL(2)) ud2 (
      .clock (clock), .clear_n (clear_n), .bus (ifd2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic init_inputs();
      if16.en = 0; if16.sel = 0; if16.scan_start = 0;
      if16.scan_first = 0; if16.scan_last = 0; if16.scan_abort = 0;
      if12.en = 0; if12.sel = 0; if12.scan_start = 0;
      if12.scan_first = 0; if12.scan_last = 0; if12.scan_abort = 0;
      ifd2.en = 0; ifd2.sel = 0; ifd2.scan_start = 0;
      ifd2.scan_first = 0; ifd2.scan_last = 0; ifd2.scan_abort = 0;
   endtask

   task automatic test_reset();
      clear_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({if16.dec_out, if16.dec_idx, if16.busy, if16.done, if16.err} !== 23'd0) begin
         errors++;
         $display("FAIL reset16: got out=%h idx=%0d busy=%b done=%b err=%b, required all 0",
                  if16.dec_out, if16.dec_idx, if16.busy, if16.done, if16.err);
      end
      checks++;
      if ({if12.dec_out, if12.dec_idx, if12.busy, if12.done, if12.err} !== 19'd0) begin
         errors++;
         $display("FAIL reset12: got out=%h idx=%0d, required all 0", if12.dec_out, if12.dec_idx);
      end
      checks++;
      if ({ifd2.dec_out, ifd2.busy, ifd2.done, ifd2.err} !== 19'd0) begin
         errors++;
         $display("FAIL reset_d2: got out=%h busy=%b, required all 0", ifd2.dec_out, ifd2.busy);
      end
      clear_n = 1'b1;
      tick();
   endtask

   task automatic test_direct();
      if16.en = 1; if16.sel = 4'd5;
      tick();
      if16.en = 0;
      checks++;
      if (if16.dec_out !== 16'h0020 || if16.dec_idx !== 4'd5 || if16.err !== 1'b0) begin
         errors++;
         $display("FAIL direct_sel5: got out=%h idx=%0d err=%b, required 0020 5 0",
                  if16.dec_out, if16.dec_idx, if16.err);
      end
      tick();
      checks++;
      if (if16.dec_out !== 16'h0000 || if16.dec_idx !== 4'd0 || if16.err !== 1'b0) begin
         errors++;
         $display("FAIL direct_strobe: got out=%h idx=%0d err=%b, required 0000 0 0",
                  if16.dec_out, if16.dec_idx, if16.err);
      end
   endtask

   task automatic test_range();
      if12.en = 1; if12.sel = 4'd13;
      tick();
      checks++;
      if (if12.dec_out !== 12'h000 || if12.err !== 1'b1) begin
         errors++;
         $display("FAIL range_sel13: got out=%h err=%b, required 000 1", if12.dec_out, if12.err);
      end
      if12.sel = 4'd11;
      tick();
      checks++;
      if (if12.dec_out !== 12'h800 || if12.dec_idx !== 4'd11 || if12.err !== 1'b0) begin
         errors++;
         $display("FAIL range_sel11: got out=%h idx=%0d err=%b, required 800 11 0",
                  if12.dec_out, if12.dec_idx, if12.err);
      end
      if12.en = 0;
      tick();
   endtask

   task automatic test_scan_dwell();
      logic [15:0] exp_seq [6];
      int busy_cnt;
      exp_seq = '{16'h0008, 16'h0008, 16'h0010, 16'h0010, 16'h0020, 16'h0020};
      busy_cnt = 0;
      ifd2.scan_start = 1; ifd2.scan_first = 4'd3; ifd2.scan_last = 4'd5;
      tick();
      ifd2.scan_start = 0;
      for (int i = 0; i < 6; i++) begin
         if (ifd2.busy === 1'b1) busy_cnt++;
         checks++;
         if (ifd2.dec_out !== exp_seq[i] || ifd2.done !== 1'b0) begin
            errors++;
            $display("FAIL scan_dwell_step%0d: got out=%h done=%b, required %h 0",
                     i, ifd2.dec_out, ifd2.done, exp_seq[i]);
         end
         tick();
      end
      checks++;
      if (ifd2.dec_out !== 16'h0000 || ifd2.done !== 1'b1 || ifd2.busy !== 1'b0) begin
         errors++;
         $display("FAIL scan_dwell_done: got out=%h done=%b busy=%b, required 0000 1 0",
                  ifd2.dec_out, ifd2.done, ifd2.busy);
      end
      checks++;
      if (busy_cnt != 6) begin
         errors++;
         $display("FAIL scan_dwell_busy: got %0d busy cycles, required 6", busy_cnt);
      end
      tick();
      checks++;
      if (ifd2.done !== 1'b0) begin
         errors++;
         $display("FAIL scan_dwell_done_pulse: got done=%b, required 0", ifd2.done);
      end
   endtask

   task automatic test_bad_range();
      if16.scan_start = 1; if16.scan_first = 4'd9; if16.scan_last = 4'd4;
      tick();
      if16.scan_start = 0;
      checks++;
      if (if16.err !== 1'b1 || if16.busy !== 1'b0 || if16.dec_out !== 16'h0000) begin
         errors++;
         $display("FAIL bad_range: got err=%b busy=%b out=%h, required 1 0 0000",
                  if16.err, if16.busy, if16.dec_out);
      end
      tick();
      checks++;
      if (if16.err !== 1'b0 || if16.busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_range_pulse: got err=%b busy=%b, required 0 0", if16.err, if16.busy);
      end
      if16.scan_start = 1; if16.scan_first = 4'd15; if16.scan_last = 4'd15;
      tick();
      if16.scan_start = 0;
      checks++;
      if (if16.dec_out !== 16'h8000 || if16.dec_idx !== 4'd15 || if16.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_idx: got out=%h idx=%0d busy=%b, required 8000 15 1",
                  if16.dec_out, if16.dec_idx, if16.busy);
      end
      tick();
      checks++;
      if (if16.dec_out !== 16'h0000 || if16.done !== 1'b1 || if16.busy !== 1'b0 || if16.err !== 1'b0) begin
         errors++;
         $display("FAIL single_idx_done: got out=%h done=%b busy=%b err=%b, required 0000 1 0 0",
                  if16.dec_out, if16.done, if16.busy, if16.err);
      end
      tick();
   endtask

   task automatic test_abort();
      int done_seen;
      if16.scan_start = 1; if16.scan_first = 4'd0; if16.scan_last = 4'd15;
      tick();
      if16.scan_start = 0;
      tick();
      tick();
      checks++;
      if (if16.dec_out !== 16'h0004 || if16.busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got out=%h busy=%b, required 0004 1", if16.dec_out, if16.busy);
      end
      if16.scan_abort = 1;
      tick();
      if16.scan_abort = 0;
      checks++;
      if (if16.dec_out !== 16'h0000 || if16.busy !== 1'b0 || if16.done !== 1'b0) begin
         errors++;
         $display("FAIL abort: got out=%h busy=%b done=%b, required 0000 0 0",
                  if16.dec_out, if16.busy, if16.done);
      end
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (if16.done !== 1'b0 || if16.dec_out !== 16'h0000) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d cycles with activity, required 0", done_seen);
      end

      if16.scan_start = 1; if16.scan_first = 4'd0; if16.scan_last = 4'd15;
      tick();
      if16.scan_start = 0;
      tick();
      tick();
      clear_n = 1'b0;
      tick();
      clear_n = 1'b1;
      checks++;
      if ({if16.dec_out, if16.dec_idx, if16.busy, if16.done, if16.err} !== 23'd0) begin
         errors++;
         $display("FAIL clear_mid_scan: got out=%h idx=%0d busy=%b done=%b err=%b, required all 0",
                  if16.dec_out, if16.dec_idx, if16.busy, if16.done, if16.err);
      end
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (if16.done !== 1'b0 || if16.busy !== 1'b0) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL clear_quiet: got %0d cycles with done/busy, required 0", done_seen);
      end
   endtask

   task automatic test_priority();
      int bad;
      if16.scan_start = 1; if16.scan_first = 4'd2; if16.scan_last = 4'd2;
      if16.en = 1; if16.sel = 4'd7;
      tick();
      if16.scan_start = 0;
      checks++;
      if (if16.dec_out !== 16'h0004 || if16.busy !== 1'b1) begin
         errors++;
         $display("FAIL scan_wins: got out=%h busy=%b, required 0004 1", if16.dec_out, if16.busy);
      end
      tick();
      if16.en = 0;
      checks++;
      if (if16.dec_out !== 16'h0000 || if16.done !== 1'b1 || if16.err !== 1'b0) begin
         errors++;
         $display("FAIL scan_wins_done: got out=%h done=%b err=%b, required 0000 1 0",
                  if16.dec_out, if16.done, if16.err);
      end
      tick();

      if16.scan_start = 1; if16.scan_first = 4'd0; if16.scan_last = 4'd5;
      tick();
      if16.scan_start = 0;
      if16.en = 1; if16.sel = 4'd7;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (if16.dec_out !== (16'd1 << i) || if16.err !== 1'b0) bad++;
         if (i < 5) tick();
      end
      if16.en = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL en_ignored_in_scan: got %0d bad cycles, required 0", bad);
      end
      tick();
      checks++;
      if (if16.dec_out !== 16'h0000 || if16.done !== 1'b1) begin
         errors++;
         $display("FAIL en_ignored_done: got out=%h done=%b, required 0000 1",
                  if16.dec_out, if16.done);
      end
      tick();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      clear_n = 1'b0;
      init_inputs();
      test_reset();
      test_direct();
      test_range();
      test_scan_dwell();
      test_bad_range();
      test_abort();
      test_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
